// File: rtl/patbuf_pkg.sv
// Shared types and helpers for the PAT pattern-buffer loader.
package patbuf_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    // The bank select lives in the top bit of the header byte.
    function automatic int hdr_bank_bit(input int d_width);
        return d_width - 1;
    endfunction

endpackage

// File: rtl/patbuf_loader_if.sv
// Byte-stream valid/ready channel feeding the pattern-buffer loader.
interface patbuf_loader_if #(
    parameter int d_width = 8
);
    logic [d_width-1:0] in_data;
    logic               in_valid;
    logic               in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/patbuf_flags.sv
// Loaded-flag vectors for both pattern-buffer banks with clear/release/set arbitration.
module patbuf_flags #(
    parameter int bufp_width = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_en,
    input  logic                    set_bank,
    input  logic [bufp_width-1:0]   set_bufp,
    input  logic                    clr_en,
    input  logic                    clr_bank,
    input  logic [bufp_width-1:0]   clr_bufp,
    input  logic                    release_en,
    input  logic                    release_bank,
    input  logic [bufp_width-1:0]   release_bufp,
    output logic [2**bufp_width-1:0] loaded_low,
    output logic [2**bufp_width-1:0] loaded_high
);

    logic [2**bufp_width-1:0] next_low;
    logic [2**bufp_width-1:0] next_high;

    // Clears are applied first so a set on the same buffer in the same cycle wins.
    always_comb begin
        next_low  = loaded_low;
        next_high = loaded_high;
        if (clr_en) begin
            if (clr_bank) next_high[clr_bufp] = 1'b0;
            else          next_low[clr_bufp]  = 1'b0;
        end
        if (release_en) begin
            if (release_bank) next_high[release_bufp] = 1'b0;
            else              next_low[release_bufp]  = 1'b0;
        end
        if (set_en) begin
            if (set_bank) next_high[set_bufp] = 1'b1;
            else          next_low[set_bufp]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loaded_low  <= '0;
            loaded_high <= '0;
        end else begin
            loaded_low  <= next_low;
            loaded_high <= next_high;
        end
    end

endmodule

// File: rtl/patbuf_loader.sv
// Decodes header/length/payload frames and writes them into the low or high pattern buffer bank.
module patbuf_loader
    import patbuf_pkg::*;
#(
    parameter int d_width      = 8,
    parameter int bufp_width   = 3,
    parameter int fieldp_width = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    patbuf_loader_if.slave                     stream,
    output logic [bufp_width+fieldp_width-1:0] buf_fieldwp,
    output logic [d_width-1:0]                 field_in,
    output logic                               field_write_en_low,
    output logic                               field_write_en_high,
    output logic [2**bufp_width-1:0]           loaded_low,
    output logic [2**bufp_width-1:0]           loaded_high,
    output logic                               load_done,
    input  logic                               release_en,
    input  logic                               release_bank,
    input  logic [bufp_width-1:0]              release_bufp
);

    localparam int bank_bit = hdr_bank_bit(d_width);

    loader_state_t           state;
    logic                    ready;
    logic                    bank;
    logic [bufp_width-1:0]   bufp;
    logic [fieldp_width-1:0] field_cnt;
    logic [fieldp_width-1:0] last_field;
    logic                    xfer;
    logic                    hdr_clr;

    assign stream.in_ready = ready;
    assign xfer            = stream.in_valid && ready;
    // The target flag drops on the header edge so a half-rewritten buffer is never seen as loaded.
    assign hdr_clr         = (state == HDR) && xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= HDR;
            ready               <= 1'b1;
            bank                <= 1'b0;
            bufp                <= '0;
            field_cnt           <= '0;
            last_field          <= '0;
            buf_fieldwp         <= '0;
            field_in            <= '0;
            field_write_en_low  <= 1'b0;
            field_write_en_high <= 1'b0;
            load_done           <= 1'b0;
        end else begin
            field_write_en_low  <= 1'b0;
            field_write_en_high <= 1'b0;
            load_done           <= 1'b0;
            case (state)
                HDR: begin
                    if (xfer) begin
                        bank  <= stream.in_data[bank_bit];
                        bufp  <= stream.in_data[bufp_width-1:0];
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        last_field <= stream.in_data[fieldp_width-1:0];
                        field_cnt  <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        buf_fieldwp         <= {bufp, field_cnt};
                        field_in            <= stream.in_data;
                        field_write_en_low  <= !bank;
                        field_write_en_high <= bank;
                        field_cnt           <= field_cnt + 1'b1;
                        if (field_cnt == last_field) begin
                            state <= DONE;
                            ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state     <= HDR;
                    ready     <= 1'b1;
                    load_done <= 1'b1;
                end
                default: begin
                    state <= HDR;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    patbuf_flags #(
        .bufp_width (bufp_width)
    ) u_flags (
        .clk          (clk),
        .reset        (reset),
        .set_en       (state == DONE),
        .set_bank     (bank),
        .set_bufp     (bufp),
        .clr_en       (hdr_clr),
        .clr_bank     (stream.in_data[bank_bit]),
        .clr_bufp     (stream.in_data[bufp_width-1:0]),
        .release_en   (release_en),
        .release_bank (release_bank),
        .release_bufp (release_bufp),
        .loaded_low   (loaded_low),
        .loaded_high  (loaded_high)
    );

endmodule

// File: tb/tb_patbuf_loader.sv
// Directed self-checking bench for patbuf_loader: frames, gaps, reload/release and mid-frame reset.
module tb_patbuf_loader;

    logic       clk;
    logic       reset;
    logic [7:0] buf_fieldwp;
    logic [7:0] field_in;
    logic       field_write_en_low;
    logic       field_write_en_high;
    logic [7:0] loaded_low;
    logic [7:0] loaded_high;
    logic       load_done;
    logic       release_en;
    logic       release_bank;
    logic [2:0] release_bufp;

    patbuf_loader_if #(.d_width(8)) stream ();

    patbuf_loader #(
        .d_width      (8),
        .bufp_width   (3),
        .fieldp_width (5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .stream              (stream.slave),
        .buf_fieldwp         (buf_fieldwp),
        .field_in            (field_in),
        .field_write_en_low  (field_write_en_low),
        .field_write_en_high (field_write_en_high),
        .loaded_low          (loaded_low),
        .loaded_high         (loaded_high),
        .load_done           (load_done),
        .release_en          (release_en),
        .release_bank        (release_bank),
        .release_bufp        (release_bufp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic       wr_bank[$];
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         both_high = 0;
    int         ready_low_cycles = 0;

    // Write-port and handshake observer, sampling mid-cycle.
    always @(negedge clk) begin
        if (field_write_en_low || field_write_en_high) begin
            wr_bank.push_back(field_write_en_high);
            wr_addr.push_back(buf_fieldwp);
            wr_data.push_back(field_in);
        end
        if (field_write_en_low && field_write_en_high) both_high++;
        if (!stream.in_ready) ready_low_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // Presents one byte from a negedge and returns at the negedge after its transfer; valid stays high.
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        waited = 0;
        stream.in_data  = b;
        stream.in_valid = 1'b1;
        while (!stream.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!stream.in_ready) begin
            checks++;
            $display("[TB] FAIL ready_timeout: got in_ready=0, expected 1 within 20 cycles");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        stream.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic clearLog();
        wr_bank.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic checkWrites(input string tag, input logic bank, input logic [7:0] base, input logic [7:0] d0, input int n, input logic [7:0] step);
        logic [7:0] exp_data;
        checkOutput({tag, "_count"}, wr_addr.size(), n);
        exp_data = d0;
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            checkOutput($sformatf("%s_bank%0d", tag, i), wr_bank[i], bank);
            checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr[i], base + 8'(i));
            checkOutput($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data);
            exp_data = exp_data + step;
        end
    endtask

    initial begin
        reset           = 1'b0;
        stream.in_data  = 8'h00;
        stream.in_valid = 1'b0;
        release_en      = 1'b0;
        release_bank    = 1'b0;
        release_bufp    = 3'd0;
        repeat (3) @(negedge clk);

        checkOutput("rst_in_ready", stream.in_ready, 1);
        checkOutput("rst_en_low", field_write_en_low, 0);
        checkOutput("rst_en_high", field_write_en_high, 0);
        checkOutput("rst_addr", buf_fieldwp, 8'h00);
        checkOutput("rst_data", field_in, 8'h00);
        checkOutput("rst_loaded_low", loaded_low, 8'h00);
        checkOutput("rst_loaded_high", loaded_high, 8'h00);
        checkOutput("rst_load_done", load_done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single frame: low bank buffer 3, three payload bytes.
        clearLog();
        applyStimulus(8'h03);
        applyStimulus(8'h02);
        applyStimulus(8'hA0);
        applyStimulus(8'hA1);
        applyStimulus(8'hA2);
        checkOutput("f1_done_ready", stream.in_ready, 0);
        checkOutput("f1_last_strobe", field_write_en_low, 1);
        checkOutput("f1_last_addr", buf_fieldwp, 8'h62);
        checkOutput("f1_flag_not_yet", loaded_low[3], 0);
        checkOutput("f1_done_early", load_done, 0);
        idleCycle();
        checkOutput("f1_flag_set", loaded_low, 8'h08);
        checkOutput("f1_load_done", load_done, 1);
        checkOutput("f1_ready_back", stream.in_ready, 1);
        idleCycle();
        checkOutput("f1_done_pulse", load_done, 0);
        checkWrites("f1", 1'b0, 8'h60, 8'hA0, 3, 8'h01);

        // Reload low/3 while loaded, with a release landing on the set edge.
        clearLog();
        applyStimulus(8'h03);
        checkOutput("rl_hdr_clears", loaded_low[3], 0);
        applyStimulus(8'h00);
        applyStimulus(8'h5A);
        stream.in_valid = 1'b0;
        release_en      = 1'b1;
        release_bank    = 1'b0;
        release_bufp    = 3'd3;
        @(negedge clk);
        release_en = 1'b0;
        checkOutput("rl_set_wins", loaded_low[3], 1);
        checkOutput("rl_load_done", load_done, 1);
        checkWrites("rl", 1'b0, 8'h60, 8'h5A, 1, 8'h00);
        release_en = 1'b1;
        @(negedge clk);
        release_en = 1'b0;
        checkOutput("rl_released", loaded_low, 8'h00);

        // Full-length high-bank frame to buffer 5.
        clearLog();
        both_high        = 0;
        ready_low_cycles = 0;
        applyStimulus(8'h85);
        applyStimulus(8'hFF);
        for (int i = 0; i < 32; i++) applyStimulus(8'h40 + 8'(3 * i));
        idleCycle();
        repeat (2) idleCycle();
        checkOutput("hi_ready_low_cycles", ready_low_cycles, 1);
        checkOutput("hi_both_strobes", both_high, 0);
        checkOutput("hi_loaded_high", loaded_high, 8'h20);
        checkOutput("hi_loaded_low", loaded_low, 8'h00);
        checkWrites("hi", 1'b1, 8'hA0, 8'h40, 32, 8'h03);

        // Payload with in_valid toggling every cycle to low/2.
        clearLog();
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hC0 + 8'(i));
            idleCycle();
            checkOutput($sformatf("gap_no_strobe%0d", i), field_write_en_low, 0);
        end
        idleCycle();
        checkOutput("gap_loaded_low", loaded_low, 8'h04);
        checkWrites("gap", 1'b0, 8'h40, 8'hC0, 4, 8'h01);

        // Abort a frame to low/4 after four of eight payload bytes.
        release_en   = 1'b1;
        release_bank = 1'b0;
        release_bufp = 3'd2;
        @(negedge clk);
        release_en = 1'b0;
        applyStimulus(8'h04);
        applyStimulus(8'h07);
        for (int i = 0; i < 4; i++) applyStimulus(8'h70 + 8'(i));
        checkOutput("mr_strobe_before", field_write_en_low, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("mr_strobe_dropped", field_write_en_low, 0);
        checkOutput("mr_in_ready", stream.in_ready, 1);
        checkOutput("mr_addr", buf_fieldwp, 8'h00);
        checkOutput("mr_data", field_in, 8'h00);
        checkOutput("mr_loaded_low", loaded_low, 8'h00);
        checkOutput("mr_loaded_high", loaded_high, 8'h00);
        stream.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mr_flag_stays", loaded_low[4], 0);

        clearLog();
        applyStimulus(8'h04);
        applyStimulus(8'h01);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        idleCycle();
        checkOutput("mr_next_loaded", loaded_low, 8'h10);
        checkOutput("mr_next_done", load_done, 1);
        checkWrites("mr", 1'b0, 8'h80, 8'h11, 2, 8'h11);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
